// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit teaching CPU.
// Widths, the halt encoding, opcodes and the fetch state type.
package cpu10_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 10;

  localparam logic [INSTR_W-1:0] HALT_WORD =
    10'b0010000010;

  typedef enum logic [3:0] {
    OP_ALU  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SYS  = 4'h2,
    OP_LD   = 4'h3,
    OP_ST   = 4'h4,
    OP_BEQ  = 4'h5,
    OP_BNE  = 4'h6,
    OP_JMP  = 4'h7,
    OP_JAL  = 4'h8,
    OP_LUI  = 4'h9
  } opcode_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM, registers the word
// for decode over valid/ready and stops after fetching halt.
module instr_fetch #(
  parameter int ADDR_W = cpu10_pkg::ADDR_W,
  parameter int INSTR_W = cpu10_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD =
    cpu10_pkg::HALT_WORD,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  address,
  input  logic [INSTR_W-1:0] read_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu10_pkg::*;

  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic run, redir, load, drain;

  assign run   = (state == RUN);
  assign redir = run && redirect_valid;
  assign load  = run && !redirect_valid &&
                 (!instr_valid || instr_ready);
  assign drain = !run && instr_valid && instr_ready;

  assign address = pc;
  assign halted  = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load && read_data == HALT_WORD)
      state_nx = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      unique case (1'b1)
        redir: begin
          // redirect squashes any held word, even mid-handshake
          pc          <= redirect_target;
          instr_valid <= 1'b0;
        end
        load: begin
          instr       <= read_data;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + ADDR_W'(1);
          if (fetch_count != '1)
            fetch_count <= fetch_count + CNT_W'(1);
        end
        drain: instr_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
